// File: rtl/mem32k_loader_if.sv
// ---------------------------------------------------------------------------
// mem32k_loader_if
//
// Groups the signals between mem32k_loader and its two neighbours:
//   - the byte stream:  byte_in, byte_valid (from source), byte_ready (to source)
//   - the 32K x 16 memory pins: mem_a, mem_d, mem_we (to memory),
//     mem_q (asynchronous read data from memory)
//
// Modports:
//   master : the loader side; drives byte_ready and the memory pins.
//   slave  : the environment side; drives the byte stream and the read data.
// ---------------------------------------------------------------------------
interface mem32k_loader_if;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic [14:0] mem_a;
  logic [15:0] mem_d;
  logic        mem_we;
  logic [15:0] mem_q;

  modport master (
    input  byte_in, byte_valid, mem_q,
    output byte_ready, mem_a, mem_d, mem_we
  );

  modport slave (
    output byte_in, byte_valid, mem_q,
    input  byte_ready, mem_a, mem_d, mem_we
  );
endinterface

// File: rtl/mem32k_loader.sv
// ---------------------------------------------------------------------------
// mem32k_loader
//
// Sequential write-side front end for a 32K x 16 single-port memory. Takes a
// byte stream, packs byte pairs little-endian (first byte -> [7:0]) into
// 16-bit words and writes them to consecutive addresses starting at a
// programmed base. Addresses wrap modulo 2^15.
//
// Optional feature (compile-time macro MEM32K_LOADER_VERIFY_EN):
//   each written word is read back through the memory's asynchronous read
//   port in an extra VERIFY cycle; the first mismatch sets the sticky
//   verify_err and records its address in err_addr. Without the macro the
//   VERIFY state does not exist, mem_q is ignored and verify_err/err_addr
//   are tied low.
//
// Ports:
//   clk           system clock, rising edge
//   reset         synchronous active-high reset
//   start         begin a load (only honoured in IDLE)
//   base_addr     first write address, latched on accepted start
//   word_count    number of words to write, latched on accepted start
//   busy          high in every state except IDLE
//   done          one-cycle pulse when a load finishes
//   words_written words written in the current/last load
//   verify_err    sticky readback mismatch flag
//   err_addr      address of the first mismatch
//   bus           byte stream and memory pins (mem32k_loader_if.master)
// ---------------------------------------------------------------------------
module mem32k_loader (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [14:0]            base_addr,
  input  logic [15:0]            word_count,
  output logic                   busy,
  output logic                   done,
  output logic [15:0]            words_written,
  output logic                   verify_err,
  output logic [14:0]            err_addr,
  mem32k_loader_if.master        bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LO,
    S_HI,
    S_WRITE,
`ifdef MEM32K_LOADER_VERIFY_EN
    S_VERIFY,
`endif
    S_DONE
  } state_t;

  state_t      state;
  logic [14:0] addr;       // address of the word being assembled/written
  logic [15:0] word;       // assembled word
  logic [15:0] remaining;  // words still to be written in this load

`ifdef MEM32K_LOADER_VERIFY_EN
  logic        verr_q;
  logic [14:0] eaddr_q;
`endif

  // NOTE: every state register here is updated with non-blocking
  // assignments so all of them see the pre-edge values of each other.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      addr          <= '0;
      word          <= '0;
      remaining     <= '0;
      words_written <= '0;
`ifdef MEM32K_LOADER_VERIFY_EN
      verr_q        <= 1'b0;
      eaddr_q       <= '0;
`endif
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            addr          <= base_addr;
            remaining     <= word_count;
            words_written <= '0;
`ifdef MEM32K_LOADER_VERIFY_EN
            verr_q        <= 1'b0;
            eaddr_q       <= '0;
`endif
            state         <= (word_count == 16'd0) ? S_DONE : S_LO;
          end
        end

        S_LO: begin
          if (bus.byte_valid) begin
            word[7:0] <= bus.byte_in;
            state     <= S_HI;
          end
        end

        S_HI: begin
          if (bus.byte_valid) begin
            word[15:8] <= bus.byte_in;
            state      <= S_WRITE;
          end
        end

        S_WRITE: begin
          words_written <= words_written + 16'd1;
          remaining     <= remaining - 16'd1;
`ifdef MEM32K_LOADER_VERIFY_EN
          state         <= S_VERIFY;
`else
          addr          <= addr + 15'd1;
          // remaining still holds the pre-decrement value here
          state         <= (remaining == 16'd1) ? S_DONE : S_LO;
`endif
        end

`ifdef MEM32K_LOADER_VERIFY_EN
        S_VERIFY: begin
          // mem_a still points at the word just written; only the first
          // mismatch of a load is recorded.
          if ((bus.mem_q != word) && !verr_q) begin
            verr_q  <= 1'b1;
            eaddr_q <= addr;
          end
          addr  <= addr + 15'd1;
          state <= (remaining == 16'd0) ? S_DONE : S_LO;
        end
`endif

        S_DONE: state <= S_IDLE;

        default: state <= S_IDLE;
      endcase
    end
  end

  // NOTE: outputs are plain continuous decodes of registered state, so no
  // combinational block exists that could leave a path unassigned.
  assign bus.byte_ready = (state == S_LO) || (state == S_HI);
  assign bus.mem_we     = (state == S_WRITE);
  assign bus.mem_a      = addr;
  assign bus.mem_d      = word;
  assign busy           = (state != S_IDLE);
  assign done           = (state == S_DONE);

`ifdef MEM32K_LOADER_VERIFY_EN
  assign verify_err = verr_q;
  assign err_addr   = eaddr_q;
`else
  assign verify_err = 1'b0;
  assign err_addr   = '0;
  // Read data is not used in this build.
  logic unused_mem_q;
  assign unused_mem_q = ^bus.mem_q;
`endif

endmodule

// File: tb/tb_mem32k_loader.sv
// ---------------------------------------------------------------------------
// tb_mem32k_loader
//
// Self-checking bench for mem32k_loader. A memory model sits on the bus; a
// feeder process offers bytes from a queue with random or alternating valid;
// the expected write sequence of each load is computed from the byte list as
// (base + i) mod 2^15 <- {byte[2i+1], byte[2i]}, and a compare process checks
// every mem_we cycle against it.
// ---------------------------------------------------------------------------
module tb_mem32k_loader;

`ifdef MEM32K_LOADER_VERIFY_EN
  localparam int  PW     = 4;
  localparam bit  VER_ON = 1'b1;
`else
  localparam int  PW     = 3;
  localparam bit  VER_ON = 1'b0;
`endif

  typedef struct {
    logic [14:0] a;
    logic [15:0] d;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [14:0] base_addr;
  logic [15:0] word_count;
  logic        busy;
  logic        done;
  logic [15:0] words_written;
  logic        verify_err;
  logic [14:0] err_addr;

  mem32k_loader_if bus ();

  mem32k_loader dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .base_addr     (base_addr),
    .word_count    (word_count),
    .busy          (busy),
    .done          (done),
    .words_written (words_written),
    .verify_err    (verify_err),
    .err_addr      (err_addr),
    .bus           (bus)
  );

  always #5 clk = ~clk;

  // ---------------- memory model ----------------
  logic [15:0] mem_arr [0:32767];
  logic        corrupt_en;
  logic [14:0] corrupt_addr;

  always @(posedge clk) begin
    if (bus.mem_we) mem_arr[bus.mem_a] <= bus.mem_d;
  end

  assign bus.mem_q = (corrupt_en && bus.mem_a == corrupt_addr) ?
                     ~mem_arr[bus.mem_a] : mem_arr[bus.mem_a];

  // ---------------- bookkeeping ----------------
  int          n_tests = 0;
  int          n_fail  = 0;
  int          done_total = 0;
  wr_t         exp_q[$];
  logic [15:0] exp_mem[int];
  logic [7:0]  feed_q[$];
  logic [7:0]  load_bytes[$];
  int          valid_pct = 100;
  bit          alt_valid = 1'b0;
  bit          hs_pending = 1'b0;
  bit          alt_phase  = 1'b0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- byte feeder ----------------
  initial begin
    bus.byte_valid = 1'b0;
    bus.byte_in    = 8'h00;
    forever begin
      @(negedge clk);
      // A handshake seen before the last edge means the byte was taken.
      if (hs_pending && feed_q.size() > 0) void'(feed_q.pop_front());
      alt_phase = ~alt_phase;
      if (feed_q.size() > 0 &&
          (alt_valid ? alt_phase : ($urandom_range(99) < valid_pct))) begin
        bus.byte_valid = 1'b1;
        bus.byte_in    = feed_q[0];
      end else begin
        bus.byte_valid = 1'b0;
        bus.byte_in    = 8'($urandom);
      end
      hs_pending = bus.byte_valid && bus.byte_ready && !reset;
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    wr_t w;
    if (!reset) begin
      if (bus.mem_we) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", 32'd1, 32'd0);
        end else begin
          w = exp_q.pop_front();
          check("wr_addr", 32'(bus.mem_a), 32'(w.a));
          check("wr_data", 32'(bus.mem_d), 32'(w.d));
        end
      end
      if (!busy) check("ready_when_idle", 32'(bus.byte_ready), 32'd0);
      if (done) done_total++;
    end
  end

  // ---------------- load driver ----------------
  task automatic run_load(input logic [14:0] base, input int count,
                          input bit poke_start, input bit check_lat,
                          input bit exp_verr, input logic [14:0] exp_eaddr);
    logic [7:0] b0, b1;
    wr_t        w;
    int         n, d0;
    bit         got;
    logic [14:0] a;
    for (int i = 0; i < count; i++) begin
      if (load_bytes.size() >= 2) begin
        b0 = load_bytes.pop_front();
        b1 = load_bytes.pop_front();
      end else begin
        b0 = 8'($urandom);
        b1 = 8'($urandom);
      end
      feed_q.push_back(b0);
      feed_q.push_back(b1);
      w.a = base + 15'(i);
      w.d = {b1, b0};
      exp_q.push_back(w);
      exp_mem[int'(w.a)] = w.d;
    end
    load_bytes.delete();

    @(negedge clk);
    base_addr  = base;
    word_count = 16'(count);
    start      = 1'b1;
    d0         = done_total;
    n          = 0;
    got        = 1'b0;
    while (!got && n < 4000) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      start      = poke_start ? 1'($urandom_range(1)) : 1'b0;
      base_addr  = 15'($urandom);
      word_count = 16'($urandom);
      if (done) got = 1'b1;
    end
    start = 1'b0;
    check("done_seen", 32'(got), 32'd1);
    if (got) begin
      check("busy_in_done", 32'(busy), 32'd1);
      if (check_lat) check("latency", 32'(n), 32'(count * PW + 1));
      check("words_written", 32'(words_written), 32'(count));
      check("verify_err", 32'(verify_err), 32'(exp_verr));
      if (exp_verr) check("err_addr", 32'(err_addr), 32'(exp_eaddr));
      else          check("err_addr", 32'(err_addr), 32'd0);
    end
    @(posedge clk);
    @(negedge clk);
    check("busy_after", 32'(busy), 32'd0);
    check("done_once", 32'(done_total - d0), 32'd1);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    for (int i = 0; i < count; i++) begin
      a = base + 15'(i);
      check("mem_content", 32'(mem_arr[a]), 32'(exp_mem[int'(a)]));
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [14:0] rb;
    int          rc;
    reset        = 1'b1;
    start        = 1'b0;
    base_addr    = '0;
    word_count   = '0;
    corrupt_en   = 1'b0;
    corrupt_addr = '0;
    for (int i = 0; i < 32768; i++) mem_arr[i] = 16'h0000;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_byte_ready", 32'(bus.byte_ready), 32'd0);
    check("rst_mem_a", 32'(bus.mem_a), 32'd0);
    check("rst_mem_d", 32'(bus.mem_d), 32'd0);
    check("rst_mem_we", 32'(bus.mem_we), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_words", 32'(words_written), 32'd0);
    check("rst_verr", 32'(verify_err), 32'd0);
    check("rst_eaddr", 32'(err_addr), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Basic two-word load, literal expectations
    valid_pct = 100; alt_valid = 1'b0;
    load_bytes = '{8'h34, 8'h12, 8'h78, 8'h56};
    run_load(15'h0010, 2, 1'b0, 1'b1, 1'b0, 15'h0);
    check("lit_0010", 32'(mem_arr[15'h0010]), 32'h1234);
    check("lit_0011", 32'(mem_arr[15'h0011]), 32'h5678);

    // Address wrap at the top of memory
    load_bytes = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    run_load(15'h7FFF, 2, 1'b0, 1'b1, 1'b0, 15'h0);
    check("lit_7fff", 32'(mem_arr[15'h7FFF]), 32'hBBAA);
    check("lit_0000", 32'(mem_arr[15'h0000]), 32'hDDCC);

    // Zero-length load: done the cycle after start, no writes
    run_load(15'h0123, 0, 1'b0, 1'b1, 1'b0, 15'h0);

    // Alternating valid, start pulses during busy ignored
    alt_valid = 1'b1;
    run_load(15'h0200, 1, 1'b1, 1'b0, 1'b0, 15'h0);
    run_load(15'h0210, 3, 1'b1, 1'b0, 1'b0, 15'h0);
    alt_valid = 1'b0;

    // Reset after low byte of word 2
    begin
      wr_t w;
      feed_q.push_back(8'h11); feed_q.push_back(8'h22); feed_q.push_back(8'h33);
      w.a = 15'h0100; w.d = 16'h2211;
      exp_q.push_back(w);
      @(negedge clk);
      base_addr = 15'h0100; word_count = 16'd3; start = 1'b1;
      repeat (PW + 2) begin
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
      end
      check("pre_rst_words", 32'(words_written), 32'd1);
      check("pre_rst_ready", 32'(bus.byte_ready), 32'd1);
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("midrst_we", 32'(bus.mem_we), 32'd0);
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_words", 32'(words_written), 32'd0);
      check("midrst_ready", 32'(bus.byte_ready), 32'd0);
      reset = 1'b0;
      repeat (4) @(negedge clk);
      feed_q.delete();
      check("midrst_w1", 32'(mem_arr[15'h0100]), 32'h2211);
      check("midrst_w2", 32'(mem_arr[15'h0101]), 32'h0000);
      check("midrst_q", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      exp_mem[32'h100] = 16'h2211;
    end

    // Readback corruption at 0x0005
    corrupt_en = 1'b1; corrupt_addr = 15'h0005;
    run_load(15'h0003, 4, 1'b0, 1'b1, VER_ON, 15'h0005);
    corrupt_en = 1'b0;

    // Randomized loads (clears verify_err from the previous load)
    for (int k = 0; k < 10; k++) begin
      rb = (k % 3 == 0) ? 15'(15'h7FFC + 15'($urandom_range(3))) : 15'($urandom);
      rc = $urandom_range(1, 6);
      valid_pct = (k % 2 == 0) ? 100 : int'($urandom_range(30, 90));
      run_load(rb, rc, k[0], (valid_pct == 100), 1'b0, 15'h0);
    end

    check("final_queue", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
